// File: rtl/cpu_bus.sv
// CPU bus: address decode for 2 KB mirrored RAM and PRG ROM, registered read data with open-bus hold.
// Optional OAM DMA engine (page copy to OAM, CPU halted) is built when OAM_DMA_EN is defined.
module cpu_bus (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_out,
  input  logic        write,
  output logic [7:0]  d_in,
  output logic        halt,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we
);

  logic [7:0]  ram [0:2047];
  logic [7:0]  data_q;
  logic        rom_sel_q;
  logic        cpu_ram;
  logic        cpu_rom;
  logic        cpu_we;
  logic [15:0] bus_addr;

  assign cpu_ram = (addr[15:13] == 3'b000);
  assign cpu_rom = addr[15];
  assign cpu_we  = !halt && write && cpu_ram;

  // ROM data arrives a cycle after its address, so the output mux is steered by a registered select
  assign d_in     = rom_sel_q ? rom_data : data_q;
  assign rom_addr = bus_addr[14:0];

  always_ff @(posedge clk) begin
    if (cpu_we)
      ram[addr[10:0]] <= d_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      rom_sel_q <= 1'b0;
    end else begin
      data_q    <= d_in;
      rom_sel_q <= 1'b0;
      if (!halt && !write) begin
        if (cpu_ram)
          data_q <= ram[addr[10:0]];
        else if (cpu_rom)
          rom_sel_q <= 1'b1;
      end
    end
  end

`ifdef OAM_DMA_EN
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] RD    = 2'd2;
  localparam logic [1:0] WR    = 2'd3;

  logic [1:0] state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] dma_q;
  logic       dma_rom_q;
  logic       trigger;

  assign halt     = (state != IDLE);
  assign trigger  = !halt && write && (addr == 16'h4014);
  assign bus_addr = (state == RD) ? {page, idx} : addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      page  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (trigger) begin
          state <= ALIGN;
          page  <= d_out;
          idx   <= '0;
        end
        ALIGN: state <= RD;
        RD:    state <= WR;
        WR: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? IDLE : RD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM/unmapped bytes are captured here; ROM bytes are taken straight from rom_data during WR
  always_ff @(posedge clk) begin
    if (state == RD) begin
      dma_rom_q <= page[7];
      if (page <= 8'h1F)
        dma_q <= ram[{page[2:0], idx}];
      else
        dma_q <= '0;
    end
  end

  assign oam_we   = (state == WR);
  assign oam_addr = (state == WR) ? idx : '0;
  assign oam_data = (state == WR) ? (dma_rom_q ? rom_data : dma_q) : '0;
`else
  assign halt     = 1'b0;
  assign bus_addr = addr;
  assign oam_we   = 1'b0;
  assign oam_addr = '0;
  assign oam_data = '0;
`endif

endmodule

// File: tb/tb_cpu_bus.sv
// Directed self-checking bench for cpu_bus; covers the DMA engine when OAM_DMA_EN is defined.
module tb_cpu_bus;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  d_out = '0;
  logic        write = 1'b0;
  logic [7:0]  d_in;
  logic        halt;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;

  logic [7:0]  rom_mem [0:32767];
  int checks = 0;
  int failures = 0;

  cpu_bus dut (
    .clk(clk), .rst(rst), .addr(addr), .d_out(d_out), .write(write),
    .d_in(d_in), .halt(halt), .rom_addr(rom_addr), .rom_data(rom_data),
    .oam_addr(oam_addr), .oam_data(oam_data), .oam_we(oam_we)
  );

  always #5 clk = ~clk;

  // synchronous ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
    addr = a;
    d_out = d;
    write = w;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dma_exp(input logic [7:0] page, input logic [7:0] i);
    if (page <= 8'h1F) return i ^ 8'hA5;
    else if (page[7]) return rom_mem[{page[6:0], i}];
    else return 8'h00;
  endfunction

  task automatic run_dma(input logic [7:0] page);
    int hc;
    int k;
    logic seen;
    hc = 0;
    k = 0;
    seen = 1'b0;
    step(16'h4014, page, 1'b1);
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (halt) begin
        hc++;
        seen = 1'b1;
      end
      if (oam_we) begin
        check("dma_oam", {oam_addr, oam_data}, {k[7:0], dma_exp(page, k[7:0])});
        k++;
      end
      if (seen && !halt) break;
      step(16'h0200, 8'hFF, 1'b1);
    end
    write = 1'b0;
    check("dma_halt_cycles", hc, 513);
    check("dma_pulses", k, 256);
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) begin
      logic [14:0] av;
      av = a[14:0];
      rom_mem[a] = av[7:0] ^ {1'b0, av[14:8]} ^ 8'h3C;
    end
    rom_mem[15'h7FFC] = 8'hC0;
    rom_mem[15'h7FFD] = 8'h3D;

    step(16'h0000, 8'h00, 1'b0);
    step(16'h0000, 8'h00, 1'b0);
    check("rst_d_in", d_in, 8'h00);
    check("rst_halt", halt, 1'b0);
    check("rst_oam_we", oam_we, 1'b0);
    check("rst_oam_addr", oam_addr, 8'h00);
    check("rst_oam_data", oam_data, 8'h00);
    rst = 1'b0;

    // RAM write/read, mirror, same-cycle d_in unaffected
    step(16'h0001, 8'h11, 1'b1);
    step(16'h0001, 8'h00, 1'b0);
    check("ram_rd_0001", d_in, 8'h11);
    step(16'h0123, 8'h5A, 1'b1);
    check("wr_no_d_in_effect", d_in, 8'h11);
    step(16'h1923, 8'h00, 1'b0);
    check("mirror_rd_1923", d_in, 8'h5A);
    step(16'h1FFF, 8'h6B, 1'b1);
    step(16'h07FF, 8'h00, 1'b0);
    check("mirror_rd_07ff", d_in, 8'h6B);
    step(16'h0000, 8'h44, 1'b1);
    step(16'h2000, 8'h99, 1'b1);
    step(16'h0000, 8'h00, 1'b0);
    check("unmapped_2000_wr", d_in, 8'h44);

    // ROM read
    addr = 16'hFFFC;
    write = 1'b0;
    #1;
    check("rom_addr", rom_addr, 15'h7FFC);
    step(16'hFFFC, 8'h00, 1'b0);
    check("rom_rd_fffc", d_in, 8'hC0);
    step(16'hFFFD, 8'h00, 1'b0);
    check("rom_rd_fffd", d_in, 8'h3D);
    step(16'h5000, 8'h00, 1'b0);
    check("open_bus_after_rom", d_in, 8'h3D);

    // open bus after RAM, unmapped write ignored
    step(16'h0001, 8'h00, 1'b0);
    check("ram_rd_0001_b", d_in, 8'h11);
    step(16'h5000, 8'h00, 1'b0);
    check("open_bus_5000", d_in, 8'h11);
    step(16'h5000, 8'h77, 1'b1);
    step(16'h5000, 8'h00, 1'b0);
    check("unmapped_wr_5000", d_in, 8'h11);

`ifdef OAM_DMA_EN
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = i[7:0];
      step({8'h02, iv}, iv ^ 8'hA5, 1'b1);
    end
    step(16'h0001, 8'h00, 1'b0);
    run_dma(8'h02);
    check("dma_d_in_hold", d_in, 8'h11);
    step(16'h0200, 8'h00, 1'b0);
    check("halt_wr_ignored", d_in, 8'hA5);

    run_dma(8'h80);
    run_dma(8'h40);

    // reset during a transfer
    begin
      int k;
      int late;
      k = 0;
      late = 0;
      step(16'h4014, 8'h02, 1'b1);
      for (int cyc = 0; cyc < 100 && k < 10; cyc++) begin
        if (oam_we) k++;
        if (k < 10) step(16'h5000, 8'h00, 1'b0);
      end
      check("abort_pulses_before", k, 10);
      rst = 1'b1;
      step(16'h5000, 8'h00, 1'b0);
      check("abort_halt", halt, 1'b0);
      check("abort_oam_we", oam_we, 1'b0);
      check("abort_d_in", d_in, 8'h00);
      rst = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        step(16'h5000, 8'h00, 1'b0);
        if (oam_we || halt) late++;
      end
      check("abort_no_more_dma", late, 0);
      step(16'h0205, 8'h00, 1'b0);
      check("ram_after_abort", d_in, 8'hA0);
    end
`else
    begin
      int hi;
      hi = 0;
      step(16'h4014, 8'h02, 1'b1);
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (halt || oam_we || (oam_addr != 8'h00) || (oam_data != 8'h00)) hi++;
        step(16'h5000, 8'h00, 1'b0);
      end
      check("nodma_outputs_zero", hi, 0);
      check("nodma_d_in_hold", d_in, 8'h11);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
